matrix_feeder: RTL and testbench

- Drives skewed operand streams into the left and top edges of the DIM×DIM systolic multiply-accumulate array.
- Captures two signed DIM×DIM matrices on a start request, clears the array accumulators, then feeds each array row and column its diagonal-delayed operands.
- Pulses done once every processing element holds its final result.
- It is the transmitting end of the operand a/b edge interface that the processing elements consume.

---
 rtl/matrix_feeder.sv | 147 ++++++++++++++
 tb/tb_matrix_feeder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_feeder.sv
// matrix_feeder: captures two signed DIM x DIM matrices on start, clears the
// systolic array, then feeds diagonally skewed operands into its left (A rows)
// and top (B columns) edges, and pulses done once every PE holds its result.
// Optional feature: define MATRIX_FEEDER_ABORT_EN to add an abort_i port that
// abandons a running job and clears the array.
module matrix_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM        = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
`ifdef MATRIX_FEEDER_ABORT_EN
  input  logic                          abort_i,
`endif
  input  logic [DIM*DIM*DATA_WIDTH-1:0] a_mat_i,
  input  logic [DIM*DIM*DATA_WIDTH-1:0] b_mat_i,
  output logic [DIM*DATA_WIDTH-1:0]     a_row_o,
  output logic [DIM*DATA_WIDTH-1:0]     b_col_o,
  output logic                          pe_rst_no,
  output logic                          busy_o,
  output logic                          done_o
);

  // One counter serves both FEED (0..2*DIM-2) and DRAIN (0..DIM-2).
  localparam int CW = $clog2(2 * DIM);
  localparam logic [CW-1:0] FEED_LAST  = CW'(2 * DIM - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DIM - 2);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [DIM*DIM*DATA_WIDTH-1:0] a_reg, b_reg;
  logic [DIM*DATA_WIDTH-1:0]     a_row_d, b_col_d;
  logic                          pe_rst_n_d, busy_d, done_d;
  logic                          abort_hit;

`ifdef MATRIX_FEEDER_ABORT_EN
  assign abort_hit = abort_i && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state and counter sequencing; abort overrides everything but reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        state_d = FEED;
        cnt_d   = '0;
      end
      FEED: begin
        if (cnt_q == FEED_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort_hit) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Output values for the upcoming cycle, so every port comes straight off a flop.
  always_comb begin
    int t;
    t          = int'(cnt_d);
    a_row_d    = '0;
    b_col_d    = '0;
    pe_rst_n_d = !((state_d == CLEAR) || abort_hit);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    if (state_d == FEED) begin
      for (int i = 0; i < DIM; i++) begin
        if ((t >= i) && (t - i < DIM)) begin
          a_row_d[i*DATA_WIDTH +: DATA_WIDTH] =
            a_reg[(i*DIM + (t - i))*DATA_WIDTH +: DATA_WIDTH];
          b_col_d[i*DATA_WIDTH +: DATA_WIDTH] =
            b_reg[((t - i)*DIM + i)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // State, counter and registered outputs; reset holds the array cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_row_o   <= '0;
      b_col_o   <= '0;
      pe_rst_no <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_row_o   <= a_row_d;
      b_col_o   <= b_col_d;
      pe_rst_no <= pe_rst_n_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
    end
  end

  // Operand matrices are sampled only at the accepting edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == IDLE) && start_i) begin
      a_reg <= a_mat_i;
      b_reg <= b_mat_i;
    end
  end

endmodule

// File: tb/tb_matrix_feeder.sv
// tb_matrix_feeder: directed checks of matrix_feeder with a behavioural
// systolic PE array attached to its edge outputs.
// With MATRIX_FEEDER_ABORT_EN defined the abort scenario is also exercised.
module tb_matrix_feeder;

  localparam int W = 32;
  localparam int D = 4;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [D*D*W-1:0] a_mat_i = '0;
  logic [D*D*W-1:0] b_mat_i = '0;
  logic [D*W-1:0]   a_row_o, b_col_o;
  logic             pe_rst_no, busy_o, done_o;

  int errors = 0;
  int checks = 0;

  matrix_feeder #(.DATA_WIDTH(W), .DIM(D)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .start_i  (start_i),
`ifdef MATRIX_FEEDER_ABORT_EN
    .abort_i  (abort_i),
`endif
    .a_mat_i  (a_mat_i),
    .b_mat_i  (b_mat_i),
    .a_row_o  (a_row_o),
    .b_col_o  (b_col_o),
    .pe_rst_no(pe_rst_no),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Behavioural PE array: A flows right, B flows down, each PE accumulates.
  logic signed [W-1:0]  pa [D][D];
  logic signed [W-1:0]  pb [D][D];
  logic signed [63:0]   acc[D][D];

  always @(posedge clk) begin
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) begin
        logic signed [W-1:0] ain, bin;
        if (c == 0) ain = a_row_o[r*W +: W];
        else        ain = pa[r][c-1];
        if (r == 0) bin = b_col_o[c*W +: W];
        else        bin = pb[r-1][c];
        if (!pe_rst_no) begin
          pa[r][c]  <= '0;
          pb[r][c]  <= '0;
          acc[r][c] <= '0;
        end else begin
          pa[r][c]  <= ain;
          pb[r][c]  <= bin;
          acc[r][c] <= acc[r][c] + 64'(ain) * 64'(bin);
        end
      end
    end
  end

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int r, input int k, input logic [W-1:0] v);
    a_mat_i[(r*D + k)*W +: W] = v;
  endtask

  task automatic set_b(input int k, input int c, input logic [W-1:0] v);
    b_mat_i[(k*D + c)*W +: W] = v;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    checks++; if (a_row_o !== '0) begin errors++; $display("[TB] FAIL reset_a_row: got %0h expected 0", a_row_o); end
    checks++; if (b_col_o !== '0) begin errors++; $display("[TB] FAIL reset_b_col: got %0h expected 0", b_col_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
    checks++; if (pe_rst_no !== 1'b0) begin errors++; $display("[TB] FAIL reset_pe_rst: got %b expected 0", pe_rst_no); end
    rst_i = 1'b0;
    step();
    checks++; if (pe_rst_no !== 1'b1) begin errors++; $display("[TB] FAIL release_pe_rst: got %b expected 1", pe_rst_no); end
  endtask

  task automatic test_identity_skew();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        set_a(r, c, (r == c) ? 32'd1 : 32'd0);
        set_b(r, c, 32'(4*r + c + 1));
      end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    checks++; if (pe_rst_no !== 1'b0) begin errors++; $display("[TB] FAIL ident_clear: got %b expected 0", pe_rst_no); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL ident_busy: got %b expected 1", busy_o); end
    for (int n = 1; n <= 11; n++) begin
      logic [W-1:0] exp_col;
      step();
      // A = I puts the single 1 of row r at feed time t = 2r, i.e. cycle 1+2r.
      for (int r = 0; r < D; r++) begin
        logic [W-1:0] exp_row;
        exp_row = (n == 1 + 2*r) ? 32'd1 : 32'd0;
        checks++;
        if (a_row_o[r*W +: W] !== exp_row) begin
          errors++;
          $display("[TB] FAIL ident_row%0d_c%0d: got %0h expected %0h", r, n, a_row_o[r*W +: W], exp_row);
        end
      end
      exp_col = (n >= 3 && n <= 6) ? 32'(4*(n-3) + 3) : 32'd0;
      checks++;
      if (b_col_o[2*W +: W] !== exp_col) begin
        errors++;
        $display("[TB] FAIL ident_col2_c%0d: got %0h expected %0h", n, b_col_o[2*W +: W], exp_col);
      end
      checks++;
      if (done_o !== (n == 11)) begin
        errors++;
        $display("[TB] FAIL ident_done_c%0d: got %b expected %b", n, done_o, (n == 11));
      end
    end
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        checks++;
        if (acc[r][c] !== 64'(4*r + c + 1)) begin
          errors++;
          $display("[TB] FAIL ident_result_%0d%0d: got %0d expected %0d", r, c, acc[r][c], 4*r + c + 1);
        end
      end
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL ident_idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_signed_passthrough();
    int done_at;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        set_a(r, c, 32'hFFFF_FFFF);
        set_b(r, c, 32'h7FFF_FFFF);
      end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    checks++; if (a_row_o[0 +: W] !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL signed_row0: got %0h expected ffffffff", a_row_o[0 +: W]); end
    checks++; if (b_col_o[0 +: W] !== 32'h7FFF_FFFF) begin errors++; $display("[TB] FAIL signed_col0: got %0h expected 7fffffff", b_col_o[0 +: W]); end
    checks++; if (a_row_o[W +: W] !== 32'h0) begin errors++; $display("[TB] FAIL signed_row1_pad: got %0h expected 0", a_row_o[W +: W]); end
    done_at = -1;
    for (int n = 2; n <= 20; n++) begin
      step();
      if (n == 7) begin
        checks++;
        if (a_row_o[3*W +: W] !== 32'hFFFF_FFFF || b_col_o[3*W +: W] !== 32'h7FFF_FFFF) begin
          errors++;
          $display("[TB] FAIL signed_last_feed: got %0h/%0h expected ffffffff/7fffffff", a_row_o[3*W +: W], b_col_o[3*W +: W]);
        end
      end
      if (done_o) begin done_at = n; break; end
    end
    checks++; if (done_at != 11) begin errors++; $display("[TB] FAIL signed_done_cycle: got %0d expected 11", done_at); end
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        checks++;
        if (acc[r][c] !== -64'sd8589934588) begin
          errors++;
          $display("[TB] FAIL signed_result_%0d%0d: got %0d expected -8589934588", r, c, acc[r][c]);
        end
      end
    step();
  endtask

  // Mixed-sign job checked against a reference product; inputs are scrambled
  // after accept to show they are not resampled.
  task automatic run_general(input string tag);
    int          av [D][D];
    int          bv [D][D];
    longint      ref_c;
    int          done_at;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        av[r][c] = r - 2*c + 1;
        bv[r][c] = 3*r - c - 4;
        set_a(r, c, 32'(av[r][c]));
        set_b(r, c, 32'(bv[r][c]));
      end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    a_mat_i = {D*D{32'h1234_5678}};
    b_mat_i = {D*D{32'h8765_4321}};
    done_at = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (done_o) begin done_at = n; break; end
    end
    checks++; if (done_at != 11) begin errors++; $display("[TB] FAIL %s_done_cycle: got %0d expected 11", tag, done_at); end
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        ref_c = 0;
        for (int k = 0; k < D; k++) ref_c += longint'(av[r][k]) * longint'(bv[k][c]);
        checks++;
        if (acc[r][c] !== 64'(ref_c)) begin
          errors++;
          $display("[TB] FAIL %s_result_%0d%0d: got %0d expected %0d", tag, r, c, acc[r][c], ref_c);
        end
      end
    step();
  endtask

  task automatic test_general();
    run_general("general");
  endtask

  task automatic test_ignored_start();
    int ndone;
    int done_at;
    int found;
    ndone = 0;
    done_at = -1;
    start_i = 1'b1;
    step();
    for (int n = 1; n <= 13; n++) begin
      step();
      if (done_o) begin ndone++; done_at = n; end
      if (n == 12) begin
        checks++; if (busy_o !== 1'b0 || pe_rst_no !== 1'b1) begin errors++; $display("[TB] FAIL ign_gap: got busy=%b pe_rst=%b expected busy=0 pe_rst=1", busy_o, pe_rst_no); end
      end
      if (n == 13) begin
        checks++; if (pe_rst_no !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("[TB] FAIL ign_next_clear: got busy=%b pe_rst=%b expected busy=1 pe_rst=0", busy_o, pe_rst_no); end
      end
    end
    start_i = 1'b0;
    checks++; if (ndone != 1) begin errors++; $display("[TB] FAIL ign_done_count: got %0d expected 1", ndone); end
    checks++; if (done_at != 11) begin errors++; $display("[TB] FAIL ign_done_cycle: got %0d expected 11", done_at); end
    found = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (done_o) begin found = 1; break; end
    end
    checks++; if (found != 1) begin errors++; $display("[TB] FAIL ign_second_job: got %0d expected 1", found); end
    step();
  endtask

  task automatic test_reset_mid_feed();
    int ndone;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        set_a(r, c, 32'(r + c + 2));
        set_b(r, c, 32'(5 - r));
      end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int n = 1; n <= 4; n++) step();
    rst_i = 1'b1;
    step();
    checks++; if (a_row_o !== '0 || b_col_o !== '0) begin errors++; $display("[TB] FAIL midrst_operands: got %0h/%0h expected 0/0", a_row_o, b_col_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy_o); end
    checks++; if (pe_rst_no !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pe_rst: got %b expected 0", pe_rst_no); end
    rst_i = 1'b0;
    ndone = 0;
    for (int n = 0; n < 15; n++) begin
      step();
      if (done_o) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", ndone); end
    checks++; if (acc[D-1][D-1] !== 64'sd0 || acc[0][0] !== 64'sd0) begin errors++; $display("[TB] FAIL midrst_cleared: got %0d/%0d expected 0/0", acc[0][0], acc[D-1][D-1]); end
  endtask

`ifdef MATRIX_FEEDER_ABORT_EN
  task automatic test_abort();
    int ndone;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        set_a(r, c, 32'(r + 1));
        set_b(r, c, 32'(c + 1));
      end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int n = 1; n <= 5; n++) step();
    abort_i = 1'b1;
    start_i = 1'b1;
    step();
    abort_i = 1'b0;
    start_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy_o); end
    checks++; if (pe_rst_no !== 1'b0) begin errors++; $display("[TB] FAIL abort_pe_rst: got %b expected 0", pe_rst_no); end
    checks++; if (a_row_o !== '0 || b_col_o !== '0) begin errors++; $display("[TB] FAIL abort_operands: got %0h/%0h expected 0/0", a_row_o, b_col_o); end
    step();
    checks++; if (pe_rst_no !== 1'b1) begin errors++; $display("[TB] FAIL abort_pe_rst_release: got %b expected 1", pe_rst_no); end
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (done_o) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", ndone); end
    run_general("after_abort");
  endtask
`endif

  initial begin
    $display("[TB] matrix_feeder bench start");
    test_reset();
    test_identity_skew();
    test_signed_passthrough();
    test_general();
    test_ignored_start();
    test_reset_mid_feed();
`ifdef MATRIX_FEEDER_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
